// File: rtl/iter_mul_unit_if.sv
// Request/response bundle for the iterative RV32M multiplier.
// The master drives the operation request; the slave returns status and the product.
interface iter_mul_unit_if;
   logic        start_i;
   logic [3:0]  ALUControl_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   modport master (
      output start_i, ALUControl_i, a_i, b_i, flush_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, ALUControl_i, a_i, b_i, flush_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/iter_mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Fixed 33-cycle latency from acceptance to the one-cycle done pulse.
module iter_mul_unit (
   input logic           clk_i,
   input logic           rst_n_i,
   iter_mul_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] OP_MUL    = 4'b1010;
   localparam logic [3:0] OP_MULH   = 4'b1011;
   localparam logic [3:0] OP_MULHSU = 4'b1100;
   localparam logic [3:0] OP_MULHU  = 4'b1101;

   state_t      state_q;
   logic [3:0]  op_q;
   logic        sign_q;
   logic [31:0] a_mag_q;
   logic [63:0] acc_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] result_q;

   logic        accept_s;
   logic        a_signed_s;
   logic        b_signed_s;
   logic        sign_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [32:0] sum_s;
   logic [63:0] acc_d;
   logic [63:0] fixed_s;
   logic [31:0] result_d;

   function automatic logic op_valid_f(input logic [3:0] op);
      case (op)
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: op_valid_f = 1'b1;
         default:                              op_valid_f = 1'b0;
      endcase
   endfunction

   // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] mag_f(input logic [31:0] v, input logic is_signed);
      if (is_signed && v[31]) begin
         mag_f = ~v + 32'd1;
      end else begin
         mag_f = v;
      end
   endfunction

   // Request decode, one shift-add step and final sign fix-up.
   always_comb begin
      accept_s   = 1'b0;
      a_signed_s = (bus.ALUControl_i == OP_MULH) || (bus.ALUControl_i == OP_MULHSU);
      b_signed_s = (bus.ALUControl_i == OP_MULH);
      if ((state_q == IDLE || state_q == DONE) && bus.start_i && op_valid_f(bus.ALUControl_i)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      a_mag_s = mag_f(bus.a_i, a_signed_s);
      b_mag_s = mag_f(bus.b_i, b_signed_s);
      sign_s  = (a_signed_s & bus.a_i[31]) ^ (b_signed_s & bus.b_i[31]);
      // Multiplier bits live in the low half and are consumed LSB first.
      sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
      acc_d   = {sum_s, acc_q[31:1]};
      fixed_s = sign_q ? (~acc_q + 64'd1) : acc_q;
      if (op_q == OP_MUL) begin
         result_d = fixed_s[31:0];
      end else begin
         result_d = fixed_s[63:32];
      end
   end

   // Control FSM with registered status outputs and datapath registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         op_q     <= 4'd0;
         sign_q   <= 1'b0;
         a_mag_q  <= 32'd0;
         acc_q    <= 64'd0;
         cnt_q    <= 5'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else if (bus.flush_i) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept_s) begin
                  state_q <= CALC;
                  op_q    <= bus.ALUControl_i;
                  sign_q  <= sign_s;
                  a_mag_q <= a_mag_s;
                  acc_q   <= {32'd0, b_mag_s};
                  cnt_q   <= 5'd0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q <= FIX;
               end else begin
                  state_q <= CALC;
               end
            end
            FIX: begin
               result_q <= result_d;
               state_q  <= DONE;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;
endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: timeline model checked every cycle
// plus directed operations with hand-computed products.
module tb_iter_mul_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic cmp_en = 1'b0;

   iter_mul_unit_if bus ();

   iter_mul_unit dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // RV32M reference: 64-bit product of suitably extended operands.
   function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = (op == 4'b1011 || op == 4'b1100) ? {{32{a[31]}}, a} : {32'd0, a};
      bx = (op == 4'b1011) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ax * bx;
      return (op == 4'b1010) ? p[31:0] : p[63:32];
   endfunction

   // Timeline model: m_k counts edges since acceptance; busy for 0..32, done at 33.
   logic        m_active = 1'b0;
   int          m_k      = 0;
   logic [31:0] m_exp    = 32'd0;
   logic [31:0] m_res    = 32'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_res    <= 32'd0;
      end else if (bus.flush_i) begin
         m_active <= 1'b0;
      end else if ((!m_active || m_k == 33) && bus.start_i &&
                   (bus.ALUControl_i inside {4'b1010, 4'b1011, 4'b1100, 4'b1101})) begin
         m_active <= 1'b1;
         m_k      <= 0;
         m_exp    <= ref_mul(bus.ALUControl_i, bus.a_i, bus.b_i);
      end else if (m_active) begin
         if (m_k == 33) begin
            m_active <= 1'b0;
         end else begin
            m_k <= m_k + 1;
            if (m_k == 32) m_res <= m_exp;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_busy",   {31'd0, bus.busy_o}, {31'd0, (m_active && m_k <= 32)});
         check("cyc_done",   {31'd0, bus.done_o}, {31'd0, (m_active && m_k == 33)});
         check("cyc_result", bus.result_o, m_res);
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start_i      = 1'b1;
      bus.ALUControl_i = op;
      bus.a_i          = a;
      bus.b_i          = b;
   endtask

   // Waits for done; start stays high with junk operands for 'hold' cycles after acceptance.
   task automatic wait_done(input string name, input logic [31:0] exp, input int hold);
      int lat    = -1;
      int busy_n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i >= hold) begin
            bus.start_i = 1'b0;
         end else begin
            bus.a_i = 32'hDEAD_BEEF;
            bus.b_i = 32'h1234_5678;
         end
         if (bus.busy_o) busy_n++;
         if (bus.done_o) begin
            lat = i;
            break;
         end
      end
      check({name, "_latency"}, lat, 32'd33);
      check({name, "_busy_cycles"}, busy_n, 32'd33);
      check({name, "_result"}, bus.result_o, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bus.start_i      = 1'b0;
      bus.ALUControl_i = 4'd0;
      bus.a_i          = 32'd0;
      bus.b_i          = 32'd0;
      bus.flush_i      = 1'b0;
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy",   {31'd0, bus.busy_o}, 32'd0);
      check("reset_done",   {31'd0, bus.done_o}, 32'd0);
      check("reset_result", bus.result_o, 32'd0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      issue(4'b1010, 32'd7, 32'd6);
      wait_done("mul_7x6", 32'h0000_002A, 0);
      repeat (2) @(negedge clk);

      issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulh_ff", 32'h0000_0000, 0);
      issue(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulhu_ff", 32'hFFFF_FFFE, 0);
      issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulhsu_ff", 32'hFFFF_FFFF, 0);
      issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mul_ff", 32'h0000_0001, 0);
      repeat (2) @(negedge clk);

      issue(4'b1011, 32'h8000_0000, 32'h8000_0000);
      wait_done("mulh_min_hold", 32'h4000_0000, 3);
      repeat (1) @(negedge clk);
      issue(4'b1100, 32'h8000_0000, 32'h0000_0002);
      wait_done("mulhsu_min", 32'hFFFF_FFFF, 0);
      repeat (2) @(negedge clk);

      // Flush ten cycles into a MUL 3*5: no done, previous result retained.
      issue(4'b1010, 32'd3, 32'd5);
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) cnt++;
      end
      check("flush_no_done", cnt, 32'd0);
      check("flush_result_kept", bus.result_o, 32'hFFFF_FFFF);
      issue(4'b1010, 32'd2, 32'd2);
      wait_done("mul_2x2", 32'h0000_0004, 0);
      repeat (2) @(negedge clk);

      // Reset asserted at CALC cycle 20 for one cycle.
      issue(4'b1010, 32'd9, 32'd9);
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("midreset_busy",   {31'd0, bus.busy_o}, 32'd0);
      check("midreset_done",   {31'd0, bus.done_o}, 32'd0);
      check("midreset_result", bus.result_o, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o) cnt++;
      end
      check("midreset_no_done", cnt, 32'd0);

      issue(4'b0000, 32'd5, 32'd5);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.busy_o) cnt++;
      end
      bus.start_i = 1'b0;
      check("badop_no_busy", cnt, 32'd0);
      issue(4'b1010, 32'd7, 32'd6);
      wait_done("mul_after_reset", 32'h0000_002A, 0);

      // Back-to-back: new request presented while DONE.
      issue(4'b1101, 32'h0001_0000, 32'h0001_0000);
      wait_done("b2b_first", 32'h0000_0001, 0);
      issue(4'b1010, 32'd100, 32'd100);
      wait_done("b2b_second", 32'h0000_2710, 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/iter_mul_unit.md
ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

Interface
REQ-001 SHALL provide clk_i  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide start_i  input  1  request to begin a multiply.
REQ-004 SHALL provide ALUControl_i  input  4  op code from decoder: 1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU.
REQ-005 SHALL provide a_i  input  32  rs1 operand; b_i  input  32  rs2 operand.
REQ-006 SHALL provide flush_i  input  1  abort in-flight operation.
REQ-007 SHALL provide busy_o  output  1  operation in progress, pipeline must stall.
REQ-008 SHALL provide done_o  output  1  one-cycle result-valid pulse.
REQ-009 SHALL provide result_o  output  32  product word for the accepted op.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-011 SHALL accept a request on a rising edge when state is IDLE or DONE, start_i=1 and ALUControl_i in {1010,1011,1100,1101}; other ALUControl_i values with start_i SHALL cause no state change.
REQ-012 SHALL on acceptance latch op, sign of result, and |a|, |b| as 32-bit unsigned magnitudes: a signed for MULH/MULHSU, b signed for MULH only; |0x80000000| = 0x80000000.
REQ-013 SHALL ignore start_i while in CALC or FIX (no re-latch, no restart).
REQ-014 SHALL in CALC perform one radix-2 shift-add step per cycle on a 64-bit unsigned accumulator, exactly 32 cycles, then go to FIX.
REQ-015 SHALL in FIX two's-complement negate the 64-bit product when latched sign is 1, select low word (MUL) or high word (MULH/MULHSU/MULHU) into result_o, go to DONE.
REQ-016 SHALL have fixed latency: DONE entered on the 33rd rising edge after the accepting edge, independent of operand values (no zero early-out).
REQ-017 SHALL assert busy_o in CALC and FIX only; done_o in DONE only, exactly one cycle; DONE returns to IDLE unless a new request is accepted (back-to-back allowed, going to CALC).
REQ-018 SHALL hold result_o stable from DONE until the next FIX overwrites it.
REQ-019 SHALL on flush_i=1 go to IDLE on the next edge from any state, no done_o, result_o unchanged; flush_i SHALL take priority over start_i in the same cycle.
REQ-020 SHALL produce results bit-exact to RV32M semantics for all operands, including 0x80000000 corner cases.

Reset
REQ-021 SHALL on rst_n_i=0 immediately (asynchronously) force state IDLE, busy_o=0, done_o=0, result_o=0x00000000, accumulator and latched operands zero.
REQ-022 SHALL on reset asserted mid-operation discard the operation with no done_o after release; first request after release SHALL behave as from power-up.

Verification
REQ-023 SHALL verify MUL a=7 b=6 -> done_o on 33rd edge after accept, result_o=0x0000002A, busy_o high exactly 32+1 cycles.
REQ-024 SHALL verify a=b=0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
REQ-025 SHALL verify MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0x80000000 b=0x00000002 -> 0xFFFFFFFF.
REQ-026 SHALL verify flush_i pulsed 10 cycles after accepting MUL 3*5 -> IDLE next edge, no done_o, result_o keeps prior value; new MUL 2*2 then -> 0x00000004.
REQ-027 SHALL verify rst_n_i low for one cycle at CALC cycle 20 -> outputs zero immediately, no done_o; start_i ignored during CALC and with ALUControl_i=0000 in IDLE -> no busy_o.
REQ-028 SHALL verify back-to-back: start_i held with new operands during DONE -> accepted, second done_o 33 edges later with correct value.
